// File: rtl/board_m_pkg.sv
// Shared types and constants for the move-submission board.
// Holds the index/flag types, turn encoding, cell codes, status codes and
// the table of the eight winning lines (row-major cell indices).
package board_m_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned GRID_W    = 2 * NUM_CELLS;
  localparam int unsigned NUM_LINES = 8;

  typedef logic [3:0] index_t;
  typedef logic       flag_t;

  typedef enum logic {
    TURN_PLAYER = 1'b0,
    TURN_AI     = 1'b1
  } turn_e;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'b00,
    CELL_PLAYER = 2'b01,
    CELL_AI     = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    ST_PLAYING    = 2'b00,
    ST_WIN_PLAYER = 2'b01,
    ST_WIN_AI     = 2'b10,
    ST_DRAW       = 2'b11
  } status_e;

  // rows, columns, diagonals
  localparam int unsigned LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

endpackage

// File: rtl/win_detect_m.sv
// Combinational line/fill detector for a 3x3 grid.
// Ports:
//   grid        in  18  cell i at [2i+1:2i] (00 empty, 01 player, 10 AI)
//   player_line out  1  some line fully owned by the player
//   ai_line     out  1  some line fully owned by the AI
//   full        out  1  no empty cell remains
module win_detect_m
  import board_m_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  output logic              player_line,
  output logic              ai_line,
  output logic              full
);

  always_comb begin
    player_line = 1'b0;
    ai_line     = 1'b0;
    full        = 1'b1;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (grid[2*i +: 2] == CELL_EMPTY) full = 1'b0;
    end
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      if (grid[2*LINES[l][0] +: 2] == CELL_PLAYER &&
          grid[2*LINES[l][1] +: 2] == CELL_PLAYER &&
          grid[2*LINES[l][2] +: 2] == CELL_PLAYER)
        player_line = 1'b1;
      if (grid[2*LINES[l][0] +: 2] == CELL_AI &&
          grid[2*LINES[l][1] +: 2] == CELL_AI &&
          grid[2*LINES[l][2] +: 2] == CELL_AI)
        ai_line = 1'b1;
    end
  end

endmodule

// File: rtl/board_m.sv
// Authoritative 3x3 board at the receiving end of the move-submission bus.
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   update_loc  cell index 0..8 from the active mover
//   submit      request level; rising edge forms one request
//   reset       game-reset request, qualified by submit
//   turn        0 player / 1 AI; selects which mover owns the bus
//   cells       2 bits per cell, cell i at [2i+1:2i]
//   status      00 playing, 01 player win, 10 AI win, 11 draw
//   move_count  accepted moves this game
//   illegal     one-cycle pulse on a rejected move request
module board_m
  import board_m_pkg::*;
#(
  parameter logic        FIRST_TURN = 1'b0,
  parameter int unsigned IDX_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  update_loc,
  input  logic              submit,
  input  logic              reset,
  output logic              turn,
  output logic [GRID_W-1:0] cells,
  output logic [1:0]        status,
  output logic [3:0]        move_count,
  output logic              illegal
);

  logic [GRID_W-1:0] cells_q, cells_d, grid_next;
  status_e           status_q, status_d;
  logic [3:0]        count_q, count_d;
  turn_e             turn_q, turn_d;
  logic              illegal_q, illegal_d;
  logic              submit_q;

  logic  req, game_rst, move_req, loc_ok, target_empty, accept;
  logic  player_line, ai_line, full, mover_line;
  cell_e mover_code;

  assign req        = submit & ~submit_q;
  assign game_rst   = req & reset;
  assign move_req   = req & ~reset;
  assign loc_ok     = update_loc <= IDX_W'(NUM_CELLS - 1);
  assign mover_code = (turn_q == TURN_PLAYER) ? CELL_PLAYER : CELL_AI;
  assign accept     = move_req && status_q == ST_PLAYING && loc_ok && target_empty;

  // Target lookup and the speculative post-write grid; the detector always
  // looks at the grid as it would be after this edge's move.
  always_comb begin
    target_empty = 1'b0;
    grid_next    = cells_q;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      if (update_loc == IDX_W'(i)) begin
        target_empty = (cells_q[2*i +: 2] == CELL_EMPTY);
        if (accept) grid_next[2*i +: 2] = mover_code;
      end
    end
  end

  win_detect_m u_win_detect (
    .grid        (grid_next),
    .player_line (player_line),
    .ai_line     (ai_line),
    .full        (full)
  );

  // Only the mover that just placed can have completed a line.
  assign mover_line = (turn_q == TURN_PLAYER) ? player_line : ai_line;

  always_comb begin
    cells_d   = cells_q;
    status_d  = status_q;
    count_d   = count_q;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    if (game_rst) begin
      cells_d  = '0;
      status_d = ST_PLAYING;
      count_d  = '0;
      turn_d   = turn_e'(FIRST_TURN);
    end else if (accept) begin
      cells_d = grid_next;
      count_d = count_q + 4'd1;
      if (mover_line)
        status_d = (turn_q == TURN_PLAYER) ? ST_WIN_PLAYER : ST_WIN_AI;
      else if (full)
        status_d = ST_DRAW;
      else
        status_d = ST_PLAYING;
      if (status_d == ST_PLAYING)
        turn_d = (turn_q == TURN_PLAYER) ? TURN_AI : TURN_PLAYER;
    end else if (move_req) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cells_q   <= '0;
      status_q  <= ST_PLAYING;
      count_q   <= '0;
      turn_q    <= turn_e'(FIRST_TURN);
      illegal_q <= 1'b0;
      submit_q  <= 1'b0;
    end else begin
      cells_q   <= cells_d;
      status_q  <= status_d;
      count_q   <= count_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      submit_q  <= submit;
    end
  end

  assign turn       = turn_q;
  assign cells      = cells_q;
  assign status     = status_q;
  assign move_count = count_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_board_m.sv
module tb_board_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  update_loc = '0;
  logic        submit = 1'b0;
  logic        reset = 1'b0;
  logic        turn;
  logic [17:0] cells;
  logic [1:0]  status;
  logic [3:0]  move_count;
  logic        illegal;

  always #5 clk = ~clk;

  board_m #(.FIRST_TURN(1'b0), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .update_loc (update_loc),
    .submit     (submit),
    .reset      (reset),
    .turn       (turn),
    .cells      (cells),
    .status     (status),
    .move_count (move_count),
    .illegal    (illegal)
  );

  typedef struct {
    string       name;
    logic [17:0] cells;
    logic [1:0]  status;
    logic [3:0]  mc;
    logic        turn;
    logic        illegal;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] c(int i, logic [1:0] code);
    return 18'(code) << (2 * i);
  endfunction

  // Monitor: tracks request edges independently and compares the state
  // presented on the following falling edge against the queued expectation.
  logic sub_q_m  = 1'b0;
  logic req_seen = 1'b0;

  always @(posedge clk) begin
    req_seen <= !rst && submit && !sub_q_m;
    sub_q_m  <= rst ? 1'b0 : submit;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_seen) begin
        if (sbq.size() == 0) begin
          chk("sb_empty_on_req", 32'(sbq.size()), 32'd1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk({e.name, ".cells"},   32'(cells),      32'(e.cells));
          chk({e.name, ".status"},  32'(status),     32'(e.status));
          chk({e.name, ".count"},   32'(move_count), 32'(e.mc));
          chk({e.name, ".turn"},    32'(turn),       32'(e.turn));
          chk({e.name, ".illegal"}, 32'(illegal),    32'(e.illegal));
        end
      end else begin
        chk("illegal_idle", 32'(illegal), 32'd0);
      end
    end
  end

  task automatic push(string nm, logic [17:0] ec, logic [1:0] es, int emc, logic et, logic eill);
    exp_t e;
    e.name = nm; e.cells = ec; e.status = es; e.mc = 4'(emc); e.turn = et; e.illegal = eill;
    sbq.push_back(e);
  endtask

  // One request: submit high one clk, then low one clk.
  task automatic do_req(string nm, int loc, logic rs, logic [17:0] ec, logic [1:0] es,
                        int emc, logic et, logic eill);
    @(negedge clk);
    push(nm, ec, es, emc, et, eill);
    update_loc = 4'(loc);
    reset      = rs;
    submit     = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic game_reset(string nm);
    do_req(nm, 0, 1'b1, '0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  int          seq4 [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  logic [17:0] g;

  initial begin
    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.cells",   32'(cells),      32'd0);
    chk("rst.status",  32'(status),     32'd0);
    chk("rst.count",   32'(move_count), 32'd0);
    chk("rst.turn",    32'(turn),       32'd0);
    chk("rst.illegal", 32'(illegal),    32'd0);
    mon_en = 1'b1;

    // 2: player wins on the top row, then a move after the win is rejected
    g = c(0, 2'b01);
    do_req("t2_p0", 0, 1'b0, g, 2'b00, 1, 1'b1, 1'b0);
    g |= c(4, 2'b10);
    do_req("t2_a4", 4, 1'b0, g, 2'b00, 2, 1'b0, 1'b0);
    g |= c(2, 2'b01);
    do_req("t2_p2", 2, 1'b0, g, 2'b00, 3, 1'b1, 1'b0);
    g |= c(8, 2'b10);
    do_req("t2_a8", 8, 1'b0, g, 2'b00, 4, 1'b0, 1'b0);
    g |= c(1, 2'b01);
    do_req("t2_p1_win", 1, 1'b0, g, 2'b01, 5, 1'b0, 1'b0);
    do_req("t2_after_win", 7, 1'b0, g, 2'b01, 5, 1'b0, 1'b1);

    // 3: occupied cell and out-of-range index rejected
    game_reset("t3_rst");
    do_req("t3_p0", 0, 1'b0, c(0, 2'b01), 2'b00, 1, 1'b1, 1'b0);
    do_req("t3_a0_occ", 0, 1'b0, c(0, 2'b01), 2'b00, 1, 1'b1, 1'b1);
    do_req("t3_a9_range", 9, 1'b0, c(0, 2'b01), 2'b00, 1, 1'b1, 1'b1);
    do_req("t3_a3", 3, 1'b0, c(0, 2'b01) | c(3, 2'b10), 2'b00, 2, 1'b0, 1'b0);

    // 4: full board with no line is a draw; turn holds on the 9th move
    game_reset("t4_rst");
    g = '0;
    for (int k = 0; k < 9; k++) begin
      g |= c(seq4[k], (k % 2 == 1) ? 2'b10 : 2'b01);
      do_req($sformatf("t4_m%0d", k), seq4[k], 1'b0, g,
             (k == 8) ? 2'b11 : 2'b00, k + 1,
             (k == 8) ? 1'b0 : 1'((k + 1) % 2), 1'b0);
    end

    // 5: game reset mid-game ignores update_loc
    game_reset("t5_rst0");
    do_req("t5_p0", 0, 1'b0, c(0, 2'b01), 2'b00, 1, 1'b1, 1'b0);
    do_req("t5_a1", 1, 1'b0, c(0, 2'b01) | c(1, 2'b10), 2'b00, 2, 1'b0, 1'b0);
    do_req("t5_p2", 2, 1'b0, c(0, 2'b01) | c(1, 2'b10) | c(2, 2'b01), 2'b00, 3, 1'b1, 1'b0);
    do_req("t5_greset", 8, 1'b1, '0, 2'b00, 0, 1'b0, 1'b0);
    do_req("t5_p8", 8, 1'b0, c(8, 2'b01), 2'b00, 1, 1'b1, 1'b0);

    // 6: held submit yields one request; rst mid-hold re-arms it
    game_reset("t6_rst");
    @(negedge clk);
    push("t6_hold", c(3, 2'b01), 2'b00, 1, 1'b1, 1'b0);
    update_loc = 4'd3;
    submit     = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push("t6_after_rst", c(3, 2'b01), 2'b00, 1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    submit = 1'b0;

    // drain with a bounded wait
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_m.md
Name: board_m

Overview:
- Receiving end of the move-submission bus shared by player_m and the AI.
- Samples update_loc/submit/reset and owns the authoritative 3x3 grid.
- Drives the turn flag that gates which mover owns the bus, and flags illegal moves, wins and draws.
- Sits between the movers and any display or logging logic.

Parameters:
- FIRST_TURN, 0 (`TURN_PLAYER): turn value after rst or game reset.
- IDX_W, 4: width of update_loc; must match `INDEX_T.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high; clears all state
- update_loc  in  IDX_W  cell index 0..8, row-major, from the active mover
- submit  in  1  request strobe from the active mover (level, edge-detected here)
- reset  in  1  game-reset request, qualified by submit
- turn  out  1  0 = `TURN_PLAYER, 1 = `TURN_AI; gates the movers' tri-state drivers
- cells  out  18  2 bits per cell, cell i at [2i+1:2i]: 00 empty, 01 player, 10 AI
- status  out  2  00 PLAYING, 01 WIN_PLAYER, 10 WIN_AI, 11 DRAW
- move_count  out  4  accepted moves this game, 0..9
- illegal  out  1  one-cycle pulse on rejected request

Behaviour:
- rst=1 at a clk edge: cells=0, status=PLAYING, move_count=0, turn=FIRST_TURN, illegal=0, submit history register=0.
- Request detect: req = submit & ~submit_q, where submit_q is submit registered each clk.
  - submit must be high ≥1 clk and low ≥1 clk between requests.
  - A level held high produces exactly one request.
- update_loc and reset are sampled at the same edge req is seen.
- Latency: all effects of a request are visible one clk after the edge where req=1.
- Game reset (req & reset):
  - cells cleared, move_count=0, status=PLAYING, turn=FIRST_TURN.
  - update_loc is ignored.
  - Legal in any status; illegal stays 0.
  - If turn was already FIRST_TURN, turn shows no transition, so no new turn edge is created.
- Move (req & ~reset) is accepted iff all of:
  - status==PLAYING
  - update_loc ≤ 8
  - the target cell is empty
- Accepted move:
  - cell written with the mover code (01 if turn==0, 10 if turn==1).
  - move_count increments.
  - status is recomputed from the post-write grid in the same edge.
  - turn toggles only if the new status==PLAYING; otherwise turn holds.
- Rejected move: grid, turn, move_count and status all unchanged; illegal=1 for exactly one clk.
- Status evaluation:
  - Check 8 lines: rows {0,1,2}{3,4,5}{6,7,8}, cols {0,3,6}{1,4,7}{2,5,8}, diags {0,4,8}{2,4,6}.
  - Win is attributed to the mover that just placed.
  - Win takes priority over draw when the 9th move completes a line.
  - DRAW when move_count reaches 9 with no line.
- Once status≠PLAYING, only a game reset changes state.
- rst takes precedence over any req in the same cycle. rst mid-hold of submit clears submit_q, so a still-high submit generates one req on the first edge after rst deasserts.
- Bus contention and Z/X on inputs are outside the contract; the bench never drives them while submit is high.

Decomposition:
- Shared defines.v holds:
  - `INDEX_T, `FLAG_T
  - `TURN_PLAYER=0, `TURN_AI=1
  - cell codes `CELL_EMPTY/`CELL_PLAYER/`CELL_AI
  - status codes `ST_PLAYING/`ST_WIN_PLAYER/`ST_WIN_AI/`ST_DRAW
- Sub-module win_detect_m (combinational): input 18-bit grid; outputs player_line, ai_line, full.
- board_m instantiates win_detect_m once, on the next-grid value.

Test Plan:
1. rst for 2 clks, then release -> cells=0, status=00, move_count=0, turn=0, illegal=0.
2. Player submits 0, AI 4, player 2, AI 8, player 1 -> after the 5th request, cells[5:0]=010101, status=01, turn holds at 0, move_count=5. A subsequent AI submit of 7 -> illegal pulse of 1 clk, grid unchanged.
3. Player 0 accepted; AI submits 0 -> illegal=1 one clk, turn stays 1. AI submits 9 -> illegal again. AI submits 3 -> accepted, turn=0.
4. Move sequence 0,1,2,4,3,5,7,6,8 (no line) -> after the 9th move, status=11, move_count=9, turn holds.
5. Mid-game (move_count=3): submit with reset=1, update_loc=8 -> cells=0, move_count=0, turn=0, illegal=0. Then submit 8 -> cell 8 = 01.
6. Hold submit high 5 clks with update_loc=3 -> exactly one move and no illegal pulse. Assert rst while submit is still high, then release -> one new req after release, cell 3 written.
